// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
// Moore controller for an N-bit shift-and-add multiplier. The product
// register holds {accumulator, multiplier}; each operation loads the
// operands, runs exactly N/2 add-and-shift-right steps, then pulses done.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request a multiplication (only honoured while ready=1)
//   mult_lsb  product register bit 0, the current multiplier LSB
//   ready     high while idle
//   ld        product register parallel load (acc=0, multiplier=operand)
//   ld_mc     multiplicand register load
//   shr       add-and-shift-right enable
//   add_en    gates the multiplicand onto the adder b-input
//   cnt       iterations completed in the current operation
//   done      one-cycle pulse; product is valid while it is high
//
// Handshake: start is a level sampled at a rising edge only while ready=1;
// anything on start in other states is dropped. done is a single-cycle
// strobe with no back-pressure.
//
// N must be even and at least 4.
module shift_add_mult_ctrl #(
    parameter int N  = 8,
    parameter int CW = $clog2(N/2) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mult_lsb,
    output logic          ready,
    output logic          ld,
    output logic          ld_mc,
    output logic          shr,
    output logic          add_en,
    output logic [CW-1:0] cnt,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(N/2 - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready      = 1'b0;
        ld         = 1'b0;
        ld_mc      = 1'b0;
        shr        = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = LOAD;
            end
            LOAD: begin
                ld         = 1'b1;
                ld_mc      = 1'b1;
                cnt_next   = '0;
                state_next = CALC;
            end
            CALC: begin
                shr      = 1'b1;
                cnt_next = cnt + ONE;
                // The last step leaves cnt at N/2, which DONE then holds.
                if (cnt == LAST_STEP) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Combinational so the LSB present during a step decides that step's add.
    assign add_en = shr & mult_lsb;

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Moore FSM that sequences the N-bit shift-and-add product register.
- The product register holds {accumulator[N-1:N/2], multiplier[N/2-1:0]}; the multiplicand is presented on the adder's b-input through an AND gate driven by add_en.
- Per operation the controller loads the operands, issues exactly N/2 add-and-shift-right steps, then signals completion. It sits between the top-level start/done handshake and the product register's ld/shr controls.

Parameters:
- N, 8, product register width; must be even and >= 4. N/2 is the operand width and the iteration count.
- CW, $clog2(N/2)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a multiplication; sampled only in IDLE.
- mult_lsb  input  1  product register bit 0 (current multiplier LSB).
- ready  output  1  high in IDLE only.
- ld  output  1  product register parallel load (accumulator=0, multiplier=operand).
- ld_mc  output  1  multiplicand register load.
- shr  output  1  product register add-and-shift-right enable.
- add_en  output  1  gates multiplicand onto adder b-input; 0 selects adding zero.
- cnt  output  CW  iterations completed in the current operation.
- done  output  1  one-cycle completion pulse; product valid while done=1.

Behaviour:
- States: IDLE, LOAD, CALC, DONE. State and cnt are registered; all control outputs decode from state (Moore), except add_en.
- add_en = shr & mult_lsb, combinational, so the current LSB decides the add in the same cycle as the shift.
- Reset (rst=1 at a rising edge): next state IDLE, cnt=0. Outputs after the edge: ready=1; ld, ld_mc, shr, add_en, done all 0.
- Reset overrides everything, including mid-CALC. The aborted operation leaves no pending state; the datapath contents are don't-care.
- IDLE: ready=1. If start=1 -> LOAD, else stay.
- LOAD (1 cycle): ld=1, ld_mc=1, cnt cleared to 0. Unconditionally -> CALC.
- CALC: shr=1 every cycle; cnt increments at each edge. When cnt==N/2-1 at an edge -> DONE, with cnt becoming N/2. CALC therefore lasts exactly N/2 cycles, regardless of multiplier value.
- DONE (1 cycle): done=1, shr=0, cnt holds N/2. Unconditionally -> IDLE.
- start is ignored outside IDLE, including in the DONE cycle; no queuing.
- start held high continuously gives back-to-back operations with one IDLE cycle between done and the next ld.
- Latency: start sampled at edge k -> ld high in cycle k+1 -> shr high cycles k+2..k+N/2+1 -> done high cycle k+N/2+2 -> ready high cycle k+N/2+3.
- ld and shr are never high in the same cycle. Outputs are X-free after the first reset edge.
- cnt does not wrap within an operation; it is only cleared by LOAD or rst.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> ready=1, ld=shr=done=0, cnt=0; no LOAD entered while rst=1.
- Basic op (N=8): pulse start, datapath multiplier=4'b1011, multiplicand=4'd5 -> ld and ld_mc high 1 cycle; shr high 4 cycles; add_en pattern 1,1,0,1; done 6 cycles after start sampled; product register = 55.
- Zero multiplier (N=8, 0*9) -> still 4 shr cycles with add_en=0 throughout; done at the same latency; product = 0.
- Back-to-back: start held high, operands 15*15 then 3*2 -> products 225 then 6; exactly one ready cycle between done and the second ld; start during CALC/DONE has no effect.
- Mid-operation reset: assert rst during the 2nd CALC cycle -> next cycle IDLE, ready=1, cnt=0, no done pulse. A fresh start then completes with correct latency.
- Parameter sweep N=4 and N=16 -> shr count = 2 and 8 respectively, cnt ends at N/2, done latency N/2+2; random operand pairs match a reference product.
